srambank_param: RTL and testbench

- Parametrised synchronous single-port SRAM bank; next generation of the fixed 256x80 bank.
- Adds configurable depth and width, per-segment write mask, and 1- or 2-cycle read latency with a data-valid strobe.
- Adds a post-reset zero-fill sequencer and error flags for read/write collision and out-of-range address.
- Sits behind the bank-select decode of a multi-bank SRAM array; one instance per bank.

---
 rtl/srambank_pkg.sv | 26 ++
 rtl/srambank_clear_seq.sv | 69 ++++++
 rtl/srambank_param.sv | 140 ++++++++++++++
 tb/tb_srambank_param.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/srambank_pkg.sv
// Shared types and elaboration helpers for the parametrised SRAM bank.
package srambank_pkg;

  // Zero-fill sequencer states
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Supported read latencies
  localparam int RL_ONE = 1;
  localparam int RL_TWO = 2;

  // Address width for a given depth; never narrower than one bit
  function automatic int addr_w_calc(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

  // True when the width/segment/latency combination is buildable
  function automatic bit params_legal(input int width, input int seg_width,
                                      input int read_latency);
    return (seg_width > 0) && ((width % seg_width) == 0) &&
           ((read_latency == RL_ONE) || (read_latency == RL_TWO));
  endfunction

endpackage

// File: rtl/srambank_clear_seq.sv
// Post-reset zero-fill sequencer: walks every word once, then idles until
// the next reset. busy is registered and high exactly while filling.
module srambank_clear_seq
  import srambank_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nxt_s;
  logic              busy_r;
  logic              clr_we_s;

  // State, fill counter and busy flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
      cnt_r   <= '0;
      busy_r  <= CLEAR_ON_RESET;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == CLEAR);
    end
  end

  // Next-state: write zero at the counter each CLEAR cycle, leave after the last word
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    clr_we_s    = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_we_s = 1'b1;
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + ADDR_W'(1);
        end
      end
      IDLE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign clr_we   = clr_we_s;
  assign clr_addr = cnt_r;
  assign busy     = busy_r;

endmodule

// File: rtl/srambank_param.sv
// Parametrised single-port SRAM bank: masked writes, 1/2-cycle read latency
// with dvalid strobe, post-reset zero-fill and collision/out-of-range flags.
module srambank_param
  import srambank_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int WIDTH          = 80,
  parameter int SEG_WIDTH      = 8,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int ADDR_W        = addr_w_calc(DEPTH),
  localparam int NSEG          = WIDTH / SEG_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [WIDTH-1:0]  wd,
  input  logic [NSEG-1:0]   wmask,
  input  logic              banksel,
  input  logic              read,
  input  logic              write,
  output logic [WIDTH-1:0]  dataout,
  output logic              dvalid,
  output logic              busy,
  output logic              err_rw,
  output logic              err_oob
);

  generate
    if (!params_legal(WIDTH, SEG_WIDTH, READ_LATENCY)) begin : g_bad_params
      $error("srambank_param: WIDTH must be a multiple of SEG_WIDTH and READ_LATENCY must be 1 or 2");
    end
  endgenerate

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy_s;
  logic              in_range_s;
  logic              wr_s;
  logic              rd_s;
  logic              coll_s;
  logic              oob_s;
  logic [WIDTH-1:0]  rd_word_s;
  logic [WIDTH-1:0]  pipe_data_s;
  logic              pipe_vld_s;

  srambank_clear_seq #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy_s)
  );

  // Access qualification: everything is gated off while the fill runs
  always_comb begin
    in_range_s = ({1'b0, ADDRESS} < DEPTH_EXT);
    wr_s       = banksel & ~busy_s & write;
    rd_s       = banksel & ~busy_s & read & ~write;
    coll_s     = banksel & ~busy_s & read & write;
    oob_s      = banksel & ~busy_s & (read | write) & ~in_range_s;
  end

  // Read word selection; out-of-range reads return zero
  always_comb begin
    rd_word_s = '0;
    if (in_range_s) begin
      rd_word_s = mem[ADDRESS];
    end else begin
      rd_word_s = '0;
    end
  end

  // Memory array: zero-fill port while clearing, otherwise per-segment host writes
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_s && in_range_s) begin
      for (int i = 0; i < NSEG; i++) begin
        if (wmask[i]) begin
          mem[ADDRESS][i*SEG_WIDTH +: SEG_WIDTH] <= wd[i*SEG_WIDTH +: SEG_WIDTH];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == RL_TWO) begin : g_lat2
      logic [WIDTH-1:0] s1_data_r;
      logic             s1_vld_r;

      // Extra read stage; captures pre-write data so a later write cannot disturb it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_data_r <= '0;
          s1_vld_r  <= 1'b0;
        end else begin
          s1_vld_r <= rd_s;
          if (rd_s) begin
            s1_data_r <= rd_word_s;
          end
        end
      end

      assign pipe_data_s = s1_data_r;
      assign pipe_vld_s  = s1_vld_r;
    end else begin : g_lat1
      assign pipe_data_s = rd_word_s;
      assign pipe_vld_s  = rd_s;
    end
  endgenerate

  // Output stage: dataout updates only with dvalid; error flags are one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout <= '0;
      dvalid  <= 1'b0;
      err_rw  <= 1'b0;
      err_oob <= 1'b0;
    end else begin
      dvalid  <= pipe_vld_s;
      err_rw  <= coll_s;
      err_oob <= oob_s;
      if (pipe_vld_s) begin
        dataout <= pipe_data_s;
      end
    end
  end

  assign busy = busy_s;

endmodule

// File: tb/tb_srambank_param.sv
// Bench for srambank_param: two instances (256 deep / latency 1 and 200 deep /
// latency 2) share one stimulus stream and are each compared every cycle
// against a behavioural model built from the bank's access rules.
module tb_srambank_param;

  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  address;
  logic [79:0] wd;
  logic [9:0]  wmask;
  logic        banksel;
  logic        read;
  logic        write;

  logic [79:0] dout   [2];
  logic        dv     [2];
  logic        busy   [2];
  logic        erw    [2];
  logic        eoob   [2];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;

  int          depth_m [2] = '{256, 200};
  int          lat_m   [2] = '{1, 2};
  logic [79:0] mem_m   [2][256];
  bit          vld_at  [2][NCYC];
  logic [79:0] data_at [2][NCYC];
  int          clr_left[2];
  logic [79:0] exp_dout[2];

  always #5 clk = ~clk;

  srambank_param #(
    .DEPTH(256), .WIDTH(80), .SEG_WIDTH(8), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ADDRESS(address), .wd(wd), .wmask(wmask),
    .banksel(banksel), .read(read), .write(write),
    .dataout(dout[0]), .dvalid(dv[0]), .busy(busy[0]), .err_rw(erw[0]), .err_oob(eoob[0])
  );

  srambank_param #(
    .DEPTH(200), .WIDTH(80), .SEG_WIDTH(8), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ADDRESS(address), .wd(wd), .wmask(wmask),
    .banksel(banksel), .read(read), .write(write),
    .dataout(dout[1]), .dvalid(dv[1]), .busy(busy[1]), .err_rw(erw[1]), .err_oob(eoob[1])
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input int i, input bit e_busy, input bit e_dv,
                           input bit e_rw, input bit e_oob);
    chk($sformatf("dataout[%0d]", i), dout[i], exp_dout[i]);
    chk($sformatf("dvalid[%0d]", i),  {79'b0, dv[i]},   {79'b0, e_dv});
    chk($sformatf("busy[%0d]", i),    {79'b0, busy[i]}, {79'b0, e_busy});
    chk($sformatf("err_rw[%0d]", i),  {79'b0, erw[i]},  {79'b0, e_rw});
    chk($sformatf("err_oob[%0d]", i), {79'b0, eoob[i]}, {79'b0, e_oob});
  endtask

  // Assert reset asynchronously and check outputs before any clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      clr_left[i] = depth_m[i];
      exp_dout[i] = '0;
      for (int a = 0; a < 256; a++) mem_m[i][a] = '0;
      for (int c = 0; c < NCYC; c++) vld_at[i][c] = 1'b0;
      check_all(i, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One clock edge: advance the model by the bank's rules, then compare
  task automatic step();
    bit          busy_pre, acc, inr, e_rw, e_oob, e_dv;
    int          due;
    logic [79:0] rdata;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      e_rw = 1'b0; e_oob = 1'b0; e_dv = 1'b0;
      if (!rst_n) begin
        exp_dout[i] = '0;
      end else begin
        busy_pre = (clr_left[i] > 0);
        if (busy_pre) clr_left[i]--;
        acc   = banksel && !busy_pre;
        inr   = (int'(address) < depth_m[i]);
        e_rw  = acc && read && write;
        e_oob = acc && (read || write) && !inr;
        if (acc && read && !write) begin
          rdata = inr ? mem_m[i][address] : 80'h0;
          due   = cyc + lat_m[i] - 1;
          if (due < NCYC) begin
            vld_at[i][due]  = 1'b1;
            data_at[i][due] = rdata;
          end
        end
        if (acc && write && inr) begin
          for (int s = 0; s < 10; s++)
            if (wmask[s]) mem_m[i][address][s*8 +: 8] = wd[s*8 +: 8];
        end
        e_dv = vld_at[i][cyc];
        if (e_dv) exp_dout[i] = data_at[i][cyc];
      end
      check_all(i, (!rst_n) || (clr_left[i] > 0), e_dv, e_rw, e_oob);
    end
  endtask

  task automatic drv(input logic b, input logic r, input logic w, input logic [7:0] a,
                     input logic [79:0] d, input logic [9:0] m);
    banksel = b; read = r; write = w; address = a; wd = d; wmask = m;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(1'b0, 1'b0, 1'b0, 8'd0, 80'h0, 10'h0);
  endtask

  task automatic rand_inputs();
    banksel = ($urandom_range(0, 4) != 0);
    read    = ($urandom_range(0, 1) == 1);
    write   = ($urandom_range(0, 4) < 2);
    address = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                          : 8'($urandom_range(0, 199));
    wd      = {16'($urandom()), $urandom(), $urandom()};
    wmask   = 10'($urandom());
  endtask

  initial begin
    logic [79:0] masked_exp;
    rst_n = 1'b1;
    banksel = 1'b0; read = 1'b0; write = 1'b0;
    address = 8'd0; wd = 80'h0; wmask = 10'h0;
    #2;
    do_reset();
    for (int k = 0; k < 3; k++) begin rand_inputs(); step(); end
    rst_n = 1'b1;

    // Fill starts; abort it at cycle 100 and restart from the beginning
    for (int k = 0; k < 100; k++) begin rand_inputs(); step(); end
    do_reset();
    for (int k = 0; k < 2; k++) begin rand_inputs(); step(); end
    rst_n = 1'b1;
    for (int k = 0; k < 260; k++) begin rand_inputs(); step(); end
    idle(2);

    // Filled contents read back as zero
    drv(1'b1, 1'b1, 1'b0, 8'd0,   80'h0, 10'h0);
    drv(1'b1, 1'b1, 1'b0, 8'd255, 80'h0, 10'h0);
    drv(1'b1, 1'b1, 1'b0, 8'd199, 80'h0, 10'h0);
    idle(3);

    // Masked write clears the low two bytes
    drv(1'b1, 1'b0, 1'b1, 8'd5, {80{1'b1}}, 10'h3FF);
    drv(1'b1, 1'b0, 1'b1, 8'd5, 80'h0,      10'h003);
    drv(1'b1, 1'b1, 1'b0, 8'd5, 80'h0,      10'h0);
    idle(3);
    masked_exp = 80'hFFFF_FFFF_FFFF_FFFF_0000;
    chk("masked_a", dout[0], masked_exp);
    chk("masked_b", dout[1], masked_exp);

    // Back-to-back reads, then dataout holds the last value
    drv(1'b1, 1'b0, 1'b1, 8'd1, 80'hA, 10'h3FF);
    drv(1'b1, 1'b0, 1'b1, 8'd2, 80'hB, 10'h3FF);
    drv(1'b1, 1'b0, 1'b1, 8'd3, 80'hC, 10'h3FF);
    drv(1'b1, 1'b1, 1'b0, 8'd1, 80'h0, 10'h0);
    drv(1'b1, 1'b1, 1'b0, 8'd2, 80'h0, 10'h0);
    drv(1'b1, 1'b1, 1'b0, 8'd3, 80'h0, 10'h0);
    idle(4);
    chk("hold_b", dout[1], 80'hC);

    // Collision: write wins, read dropped, err_rw pulses
    drv(1'b1, 1'b1, 1'b1, 8'd9, 80'h1234, 10'h3FF);
    drv(1'b1, 1'b1, 1'b0, 8'd9, 80'h0,    10'h0);
    idle(3);
    chk("coll_read_b", dout[1], 80'h1234);

    // Out of range for the 200-deep bank
    drv(1'b1, 1'b0, 1'b1, 8'd199, 80'h77, 10'h3FF);
    drv(1'b1, 1'b0, 1'b1, 8'd210, 80'h55, 10'h3FF);
    drv(1'b1, 1'b1, 1'b0, 8'd210, 80'h0,  10'h0);
    drv(1'b1, 1'b1, 1'b1, 8'd220, 80'h99, 10'h3FF);
    drv(1'b1, 1'b1, 1'b0, 8'd199, 80'h0,  10'h0);
    idle(3);
    chk("oob_199_b", dout[1], 80'h77);

    // Zero mask no-op, read-after-write, write behind an in-flight read
    drv(1'b1, 1'b0, 1'b1, 8'd199, 80'hDEAD, 10'h000);
    drv(1'b1, 1'b0, 1'b1, 8'd7,   80'h1111, 10'h3FF);
    drv(1'b1, 1'b1, 1'b0, 8'd7,   80'h0,    10'h0);
    drv(1'b1, 1'b0, 1'b1, 8'd7,   80'h2222, 10'h3FF);
    drv(1'b1, 1'b1, 1'b0, 8'd199, 80'h0,    10'h0);
    idle(3);

    // Randomised traffic
    for (int k = 0; k < 800; k++) begin rand_inputs(); step(); end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
